// File: rtl/cnn_pkg.sv
// Definitions shared by the convolution address generators: FSM encoding,
// geometry constants and the window end-of-line test.
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned MIN_WIDTH = 3;
  localparam int unsigned KERNEL    = 3;
  localparam int unsigned POS_W     = 12;

  // True when a window starting at pos would not fit another stride step.
  function automatic logic pos_end(input logic [POS_W-1:0] width,
                                   input logic [POS_W-1:0] pos,
                                   input logic [1:0]       stride);
    logic [POS_W+1:0] sum;
    sum = {2'b00, pos} + (POS_W+2)'(KERNEL) + {{POS_W{1'b0}}, stride};
    return ({2'b00, width} < sum);
  endfunction

endpackage

// File: rtl/out_pos_cnt.sv
// Column/row/channel raster counters with end-of-line, end-of-frame and
// end-of-layer flags.
module out_pos_cnt
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             adv_i,
  input  logic [1:0]       stride_i,
  input  logic [POS_W-1:0] width_i,
  input  logic [POS_W-1:0] channel_i,
  output logic [POS_W-1:0] ch_cnt_o,
  output logic             col_end_o,
  output logic             row_end_o,
  output logic             last_o
);

  logic [POS_W-1:0] col_q, col_d;
  logic [POS_W-1:0] row_q, row_d;
  logic [POS_W-1:0] ch_q, ch_d;
  logic [POS_W-1:0] stride_ext_s;
  logic             ch_end_s;

  assign stride_ext_s = {{(POS_W-2){1'b0}}, stride_i};
  assign col_end_o    = pos_end(width_i, col_q, stride_i);
  assign row_end_o    = pos_end(width_i, row_q, stride_i);
  assign ch_end_s     = (ch_q == (channel_i - {{(POS_W-1){1'b0}}, 1'b1}));
  assign last_o       = ch_end_s & col_end_o & row_end_o;
  assign ch_cnt_o     = ch_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ch_d  = ch_q;
    if (clear_i) begin
      col_d = {POS_W{1'b0}};
      row_d = {POS_W{1'b0}};
      ch_d  = {POS_W{1'b0}};
    end else if (adv_i) begin
      if (col_end_o) begin
        col_d = {POS_W{1'b0}};
        if (row_end_o) begin
          row_d = {POS_W{1'b0}};
          if (ch_end_s) begin
            ch_d = {POS_W{1'b0}};
          end else begin
            ch_d = ch_q + {{(POS_W-1){1'b0}}, 1'b1};
          end
        end else begin
          row_d = row_q + stride_ext_s;
          ch_d  = ch_q;
        end
      end else begin
        col_d = col_q + stride_ext_s;
        row_d = row_q;
        ch_d  = ch_q;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
      ch_d  = ch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= {POS_W{1'b0}};
      row_q <= {POS_W{1'b0}};
      ch_q  <= {POS_W{1'b0}};
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      ch_q  <= ch_d;
    end
  end

endmodule

// File: rtl/out_wr_gen.sv
// Output feature-map writer: writes channel 0 results directly and
// read-modify-writes partial sums for later channels, one cycle behind accept.
module out_wr_gen
  import cnn_pkg::*;
#(
  parameter int BRAM_ADDR_BIT = 32,
  parameter int ACC_W         = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               stride,
  input  logic [POS_W-1:0]         width,
  input  logic [POS_W-1:0]         channel,
  input  logic                     in_valid,
  input  logic [ACC_W-1:0]         in_data,
  output logic                     in_ready,
  output logic [BRAM_ADDR_BIT-1:0] bram_waddr,
  output logic                     bram_we,
  output logic [ACC_W-1:0]         bram_wdata,
  output logic [BRAM_ADDR_BIT-1:0] bram_raddr,
  output logic                     bram_ren,
  input  logic [ACC_W-1:0]         bram_rdata,
  output logic                     busy,
  output logic                     done
);

  state_e                   state_q, state_d;
  logic [1:0]               stride_q;
  logic [POS_W-1:0]         width_q;
  logic [POS_W-1:0]         channel_q;
  logic [BRAM_ADDR_BIT-1:0] wr_ptr_q;
  logic                     v_q;
  logic [ACC_W-1:0]         data_q;
  logic [BRAM_ADDR_BIT-1:0] addr_q;
  logic                     ch0_q;
  logic                     fwd_q;
  logic [ACC_W-1:0]         fwd_data_q;

  logic                     start_s;
  logic                     accept_s;
  logic                     fwd_s;
  logic [ACC_W-1:0]         rd_operand_s;
  logic [POS_W-1:0]         ch_cnt_s;
  logic                     col_end_s;
  logic                     row_end_s;
  logic                     last_s;

  assign start_s  = start & (state_q == ST_IDLE);
  assign accept_s = in_valid & (state_q == ST_RUN);

  out_pos_cnt u_pos (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (start_s),
    .adv_i     (accept_s),
    .stride_i  (stride_q),
    .width_i   (width_q),
    .channel_i (channel_q),
    .ch_cnt_o  (ch_cnt_s),
    .col_end_o (col_end_s),
    .row_end_o (row_end_s),
    .last_o    (last_s)
  );

  assign in_ready = (state_q == ST_RUN);
  assign busy     = (state_q == ST_RUN) | (state_q == ST_FLUSH);
  assign done     = (state_q == ST_DONE);

  assign bram_ren   = accept_s & (ch_cnt_s != {POS_W{1'b0}});
  assign bram_raddr = wr_ptr_q;

  assign bram_we      = v_q & ~rst;
  assign bram_waddr   = addr_q;
  // A back-to-back read of the address being written would see stale BRAM data.
  assign rd_operand_s = fwd_q ? fwd_data_q : bram_rdata;
  assign bram_wdata   = ch0_q ? data_q : (data_q + rd_operand_s);
  assign fwd_s        = bram_ren & bram_we & (bram_raddr == bram_waddr);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s & last_s) state_d = ST_FLUSH;
        else                   state_d = ST_RUN;
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      stride_q   <= 2'd0;
      width_q    <= {POS_W{1'b0}};
      channel_q  <= {POS_W{1'b0}};
      wr_ptr_q   <= {BRAM_ADDR_BIT{1'b0}};
      v_q        <= 1'b0;
      data_q     <= {ACC_W{1'b0}};
      addr_q     <= {BRAM_ADDR_BIT{1'b0}};
      ch0_q      <= 1'b1;
      fwd_q      <= 1'b0;
      fwd_data_q <= {ACC_W{1'b0}};
    end else begin
      state_q <= state_d;
      if (start_s) begin
        stride_q  <= (stride == 2'd0) ? 2'd1 : stride;
        width_q   <= width;
        channel_q <= (channel == {POS_W{1'b0}}) ? {{(POS_W-1){1'b0}}, 1'b1} : channel;
        wr_ptr_q  <= {BRAM_ADDR_BIT{1'b0}};
      end else if (accept_s) begin
        if (col_end_s & row_end_s) begin
          wr_ptr_q <= {BRAM_ADDR_BIT{1'b0}};
        end else begin
          wr_ptr_q <= wr_ptr_q + BRAM_ADDR_BIT'(1);
        end
      end
      v_q        <= accept_s;
      fwd_q      <= fwd_s;
      fwd_data_q <= bram_wdata;
      if (accept_s) begin
        data_q <= in_data;
        addr_q <= wr_ptr_q;
        ch0_q  <= (ch_cnt_s == {POS_W{1'b0}});
      end
    end
  end

endmodule

// File: tb/tb_out_wr_gen.sv
// Table-driven bench for out_wr_gen with a scoreboard of expected BRAM writes.
module tb_out_wr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  stride;
  logic [11:0] width;
  logic [11:0] channel;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] bram_waddr;
  logic        bram_we;
  logic [31:0] bram_wdata;
  logic [31:0] bram_raddr;
  logic        bram_ren;
  logic [31:0] bram_rdata;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  out_wr_gen #(.BRAM_ADDR_BIT(32), .ACC_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stride     (stride),
    .width      (width),
    .channel    (channel),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .bram_waddr (bram_waddr),
    .bram_we    (bram_we),
    .bram_wdata (bram_wdata),
    .bram_raddr (bram_raddr),
    .bram_ren   (bram_ren),
    .bram_rdata (bram_rdata),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ren;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
  } wr_t;

  vec_t tbl[$];
  wr_t  sb[$];
  wr_t  mon_w;
  int   n_vec = 0;
  int   n_miss = 0;

  // Read-first BRAM model; reset fills it with a recognisable stale pattern.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hDEAD_0000 | 32'(i);
    end else begin
      if (bram_we) mem[bram_waddr[5:0]] <= bram_wdata;
      if (bram_ren) bram_rdata <= mem[bram_raddr[5:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bram_waddr, bram_wdata);
      end else begin
        mon_w = sb.pop_front();
        check("waddr", bram_waddr, mon_w.addr);
        check("wdata", bram_wdata, mon_w.wdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic do_start(input logic [1:0] s, input logic [11:0] w, input logic [11:0] c);
    @(posedge clk); #1;
    start = 1'b1; stride = s; width = w; channel = c;
    @(posedge clk); #1;
    start = 1'b0; stride = 2'd0; width = 12'd0; channel = 12'd0;
  endtask

  task automatic send(input vec_t v, input int gap, input bit rogue);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = v.data;
    if (rogue) begin
      start = 1'b1; stride = 2'd3; width = 12'd9; channel = 12'd4;
    end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        check("ren", {31'd0, bram_ren}, {31'd0, v.ren});
        if (v.ren) check("raddr", bram_raddr, v.addr);
        sb.push_back({v.addr, v.wdata});
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_vec++; n_miss++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    in_valid = 1'b0;
    start = 1'b0; stride = 2'd0; width = 12'd0; channel = 12'd0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_layer();
    @(negedge clk);
    check("flush_ready", {31'd0, in_ready}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd1);
    check("flush_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("done", {31'd0, done}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_table(input int gap, input int rogue_at);
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i], (i == tbl.size() - 1) ? 0 : gap, (i == rogue_at));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stride = 2'd0; width = 12'd0; channel = 12'd0;
    in_valid = 1'b0; in_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we", {31'd0, bram_we}, 32'd0);
    check("rst_ren", {31'd0, bram_ren}, 32'd0);
    check("rst_waddr", bram_waddr, 32'd0);
    check("rst_wdata", bram_wdata, 32'd0);
    check("rst_raddr", bram_raddr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 3x3 output, single channel, back to back
    tbl.delete();
    for (int i = 1; i <= 9; i++) tbl.push_back({32'(i), 32'(i - 1), 32'(i), 1'b0});
    do_start(2'd1, 12'd5, 12'd1);
    run_table(0, -1);
    finish_layer();

    // 2x2 output, two channels accumulated
    tbl.delete();
    for (int i = 0; i < 4; i++) tbl.push_back({32'(10 * (i + 1)), 32'(i), 32'(10 * (i + 1)), 1'b0});
    for (int i = 0; i < 4; i++) tbl.push_back({32'(i + 1), 32'(i), 32'(11 * (i + 1)), 1'b1});
    do_start(2'd2, 12'd5, 12'd2);
    run_table(0, -1);
    finish_layer();
    for (int i = 0; i < 4; i++) check("mem_final", mem[i], 32'(11 * (i + 1)));

    // 1x1 output, three channels: every read collides with the pending write
    tbl.delete();
    tbl.push_back({32'd1, 32'd0, 32'd1, 1'b0});
    tbl.push_back({32'd2, 32'd0, 32'd3, 1'b1});
    tbl.push_back({32'd3, 32'd0, 32'd6, 1'b1});
    do_start(2'd1, 12'd3, 12'd3);
    run_table(0, -1);
    finish_layer();
    check("mem_1x1", mem[0], 32'd6);

    // stride 3 on width 7 gives 2x2
    tbl.delete();
    for (int i = 0; i < 4; i++) tbl.push_back({32'(100 + i), 32'(i), 32'(100 + i), 1'b0});
    do_start(2'd3, 12'd7, 12'd1);
    run_table(0, -1);
    finish_layer();

    // in_valid gaps; stride 0 and channel 0 normalise to 1
    tbl.delete();
    for (int i = 1; i <= 9; i++) tbl.push_back({32'(i + 50), 32'(i - 1), 32'(i + 50), 1'b0});
    do_start(2'd0, 12'd5, 12'd0);
    run_table(1, -1);
    finish_layer();

    // reset after the 4th accept drops the pending write
    tbl.delete();
    for (int i = 1; i <= 9; i++) tbl.push_back({32'(i), 32'(i - 1), 32'(i), 1'b0});
    do_start(2'd1, 12'd5, 12'd1);
    for (int i = 0; i < 4; i++) send(tbl[i], 0, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_mid_we", {31'd0, bram_we}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // restart from address 0, with a stray start mid-layer
    tbl.delete();
    for (int i = 1; i <= 9; i++) tbl.push_back({32'(i + 200), 32'(i - 1), 32'(i + 200), 1'b0});
    do_start(2'd1, 12'd5, 12'd1);
    run_table(0, 3);
    finish_layer();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
